// File: rtl/tank_rr_scheduler.sv
// ============================================================================
// Module   : tank_rr_scheduler
// Brief    : Round-robin arbiter sharing one bounded fill/drain volume counter
//            among NREQ requesters, moving one unit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tank_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int CAP   = 10000,
    parameter int CBITS = 14,
    parameter int ABITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       dir,
    input  logic [NREQ*ABITS-1:0] amt,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  short,
    output logic [CBITS-1:0]      vol,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
);

    localparam int               c_ibits = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [1:0]       c_idle  = 2'd0;
    localparam logic [1:0]       c_serve = 2'd1;
    localparam logic [1:0]       c_done  = 2'd2;
    localparam logic [CBITS-1:0] c_cap   = CBITS'(CAP);
    localparam logic [NREQ-1:0]  c_one   = NREQ'(1);
    localparam logic [c_ibits-1:0] c_ptr_rst = c_ibits'(NREQ - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_ibits-1:0] r_ptr;
    logic [c_ibits-1:0] r_idx;
    logic               r_dir;
    logic [ABITS-1:0]   r_rem;
    logic [CBITS-1:0]   r_vol;

    logic [c_ibits-1:0] w_pick;
    logic [c_ibits-1:0] w_cand;
    logic               w_any;
    logic               w_stop;
    logic [ABITS-1:0]   w_amt_sel;

    // Scan from the farthest candidate down to ptr+1 so the nearest set bit wins.
    always_comb begin
        w_pick = r_ptr;
        w_cand = '0;
        w_any  = |req;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = c_ibits'((int'(r_ptr) + k) % NREQ);
            if (req[w_cand]) begin
                w_pick = w_cand;
            end
        end
    end

    assign w_amt_sel = amt[int'(w_pick)*ABITS +: ABITS];

    assign w_stop = (r_rem == '0) || !req[r_idx] ||
                    (r_dir && (r_vol == c_cap)) || (!r_dir && (r_vol == '0));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (w_any) w_next_state = c_serve;
            c_serve: if (w_stop) w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_ptr   <= c_ptr_rst;
            r_idx   <= '0;
            r_dir   <= 1'b0;
            r_rem   <= '0;
            r_vol   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == c_idle) && w_any) begin
                r_idx <= w_pick;
                r_ptr <= w_pick;
                r_dir <= dir[w_pick];
                r_rem <= w_amt_sel;
            end
            if ((r_state == c_serve) && !w_stop) begin
                r_vol <= r_dir ? (r_vol + CBITS'(1)) : (r_vol - CBITS'(1));
                r_rem <= r_rem - ABITS'(1);
            end
        end
    end

    assign gnt   = (r_state == c_serve) ? (c_one << r_idx) : '0;
    assign done  = (r_state == c_done)  ? (c_one << r_idx) : '0;
    assign short = (r_state == c_done) && (r_rem != '0);
    assign busy  = (r_state != c_idle);
    assign vol   = r_vol;
    assign full  = (r_vol == c_cap);
    assign empty = (r_vol == '0);

endmodule

`default_nettype wire

// File: tb/tb_tank_rr_scheduler.sv
// ============================================================================
// Module   : tb_tank_rr_scheduler
// Brief    : Directed self-checking bench for tank_rr_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tank_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int CAP   = 10000;
    localparam int CBITS = 14;
    localparam int ABITS = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [NREQ*ABITS-1:0] amt;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  short;
    logic [CBITS-1:0]      vol;
    logic                  full;
    logic                  empty;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;
    bit r_over_cap = 1'b0;
    bit r_multi    = 1'b0;

    tank_rr_scheduler #(
        .NREQ(NREQ), .CAP(CAP), .CBITS(CBITS), .ABITS(ABITS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .dir(dir), .amt(amt),
        .gnt(gnt), .done(done), .short(short), .vol(vol),
        .full(full), .empty(empty), .busy(busy)
    );

    always #5 clk = ~clk;

    // Sticky invariant monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (int'(vol) > CAP) r_over_cap = 1'b1;
        if ($countones(gnt) > 1 || $countones(done) > 1) r_multi = 1'b1;
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_svc(input int i, input bit d, input int a,
                           output int gcyc, output logic shrt, output bit tmo);
        dir[i] = d;
        amt[i*ABITS +: ABITS] = ABITS'(a);
        req[i] = 1'b1;
        gcyc = 0;
        shrt = 1'b0;
        tmo  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (gnt[i]) gcyc++;
            if (done[i]) begin
                shrt = short;
                tmo  = 1'b0;
                break;
            end
        end
        req[i] = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (vol !== '0)    begin n_err++; $display("FAIL reset_vol got=%0d exp=0", vol); end
        n_vec++; if (gnt !== '0)    begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        n_vec++; if (done !== '0)   begin n_err++; $display("FAIL reset_done got=%b exp=0000", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (short !== 1'b0) begin n_err++; $display("FAIL reset_short got=%b exp=0", short); end
        n_vec++; if (empty !== 1'b1 || full !== 1'b0)
            begin n_err++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    endtask

    task automatic test_basic_fill();
        int gc; logic sh; bit to;
        do_reset();
        run_svc(0, 1'b1, 5, gc, sh, to);
        n_vec++; if (to)        begin n_err++; $display("FAIL fill5_timeout got=no_done exp=done"); end
        n_vec++; if (gc != 6)   begin n_err++; $display("FAIL fill5_gnt_cycles got=%0d exp=6", gc); end
        n_vec++; if (sh !== 1'b0) begin n_err++; $display("FAIL fill5_short got=%b exp=0", sh); end
        n_vec++; if (vol !== 14'd5) begin n_err++; $display("FAIL fill5_vol got=%0d exp=5", vol); end
    endtask

    task automatic test_round_robin();
        int order[5];
        int n = 0;
        logic [NREQ-1:0] prev = '0;
        bit fin = 1'b0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        dir = '1;
        amt = {4{8'd1}};
        req = '1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (gnt != '0 && prev == '0 && n < 5) begin
                for (int b = 0; b < NREQ; b++) if (gnt[b]) order[n] = b;
                n++;
            end
            prev = gnt;
            if (n == 5 && done != '0) begin fin = 1'b1; break; end
        end
        req = '0;
        @(posedge clk); #1;
        n_vec++; if (!fin) begin n_err++; $display("FAIL rr_timeout got=%0d grants exp=5", n); end
        for (int g = 0; g < 5; g++) begin
            n_vec++;
            if (order[g] != exp_order[g])
                begin n_err++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", g, order[g], exp_order[g]); end
        end
        n_vec++; if (r_multi) begin n_err++; $display("FAIL rr_onehot got=multi exp=onehot"); end
        n_vec++; if (vol !== 14'd5) begin n_err++; $display("FAIL rr_vol got=%0d exp=5", vol); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_drain_empty();
        int gc; logic sh; bit to;
        do_reset();
        run_svc(1, 1'b0, 3, gc, sh, to);
        n_vec++; if (to)          begin n_err++; $display("FAIL drain_empty_timeout got=no_done exp=done"); end
        n_vec++; if (gc != 1)     begin n_err++; $display("FAIL drain_empty_gnt_cycles got=%0d exp=1", gc); end
        n_vec++; if (sh !== 1'b1) begin n_err++; $display("FAIL drain_empty_short got=%b exp=1", sh); end
        n_vec++; if (vol !== '0 || empty !== 1'b1)
            begin n_err++; $display("FAIL drain_empty_vol got=%0d empty=%b exp=0 empty=1", vol, empty); end
    endtask

    task automatic test_zero_amt();
        int gc; logic sh; bit to;
        do_reset();
        run_svc(3, 1'b1, 0, gc, sh, to);
        n_vec++; if (to || sh !== 1'b0)
            begin n_err++; $display("FAIL zero_amt_short got=%b tmo=%0d exp=0", sh, to); end
        n_vec++; if (vol !== '0) begin n_err++; $display("FAIL zero_amt_vol got=%0d exp=0", vol); end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        logic sh = 1'b0;
        do_reset();
        dir[2] = 1'b1;
        amt[2*ABITS +: ABITS] = 8'd200;
        req[2] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (vol == 14'd4) req[2] = 1'b0;
            if (done[2]) begin seen = 1'b1; sh = short; break; end
        end
        req = '0;
        n_vec++; if (!seen)       begin n_err++; $display("FAIL abort_done got=none exp=pulse"); end
        n_vec++; if (sh !== 1'b1) begin n_err++; $display("FAIL abort_short got=%b exp=1", sh); end
        n_vec++; if (vol !== 14'd4) begin n_err++; $display("FAIL abort_vol got=%0d exp=4", vol); end
    endtask

    task automatic test_reset_mid_serve();
        bit stray = 1'b0;
        bit hit   = 1'b0;
        do_reset();
        dir[0] = 1'b1;
        amt[0 +: ABITS] = 8'd50;
        req[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (vol == 14'd3) begin hit = 1'b1; break; end
        end
        rst = 1'b1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (!hit || vol !== '0 || gnt !== '0 || busy !== 1'b0)
            begin n_err++; $display("FAIL rst_mid got vol=%0d gnt=%b busy=%b exp 0 0000 0", vol, gnt, busy); end
        for (int c = 0; c < 5; c++) begin
            if (done != '0) stray = 1'b1;
            @(posedge clk); #1;
        end
        n_vec++; if (stray) begin n_err++; $display("FAIL rst_mid_done got=pulse exp=none"); end
    endtask

    task automatic test_fill_to_cap();
        int gc; logic sh; bit to;
        bit any_to = 1'b0;
        do_reset();
        for (int s = 0; s < 39; s++) begin
            run_svc(0, 1'b1, 255, gc, sh, to);
            any_to |= to;
        end
        run_svc(0, 1'b1, 53, gc, sh, to);
        any_to |= to;
        n_vec++; if (any_to || vol !== 14'(CAP - 2))
            begin n_err++; $display("FAIL preload_vol got=%0d exp=%0d", vol, CAP - 2); end
        run_svc(1, 1'b1, 10, gc, sh, to);
        n_vec++; if (to || gc != 3) begin n_err++; $display("FAIL cap_gnt_cycles got=%0d exp=3", gc); end
        n_vec++; if (sh !== 1'b1)   begin n_err++; $display("FAIL cap_short got=%b exp=1", sh); end
        n_vec++; if (vol !== 14'(CAP) || full !== 1'b1)
            begin n_err++; $display("FAIL cap_vol got=%0d full=%b exp=%0d full=1", vol, full, CAP); end
        run_svc(2, 1'b0, 1, gc, sh, to);
        n_vec++; if (to || sh !== 1'b0 || vol !== 14'(CAP - 1) || full !== 1'b0)
            begin n_err++; $display("FAIL cap_drain1 got=%0d short=%b exp=%0d short=0", vol, sh, CAP - 1); end
        n_vec++; if (r_over_cap) begin n_err++; $display("FAIL cap_bound got=exceeded exp=vol<=CAP"); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        dir = '0;
        amt = '0;
        test_reset();
        test_basic_fill();
        test_round_robin();
        test_drain_empty();
        test_zero_amt();
        test_abort();
        test_reset_mid_serve();
        test_fill_to_cap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
